// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port asynchronous SRAM arbiter.
package sram_arb_pkg;

  localparam int SRAM_ADDR_W = 18;
  localparam int SRAM_DATA_W = 16;
  localparam int NUM_PORTS   = 2;
  localparam int PORT_IDX_W  = 1;
  localparam int CNT_W       = 4;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    FINISH
  } arb_state_e;

  typedef struct packed {
    logic                   we;
    logic [SRAM_ADDR_W-1:0] addr;
    logic [SRAM_DATA_W-1:0] wdata;
    logic [1:0]             be;
    logic [PORT_IDX_W-1:0]  port;
  } xfer_t;

  typedef struct packed {
    logic ce_n;
    logic we_n;
    logic oe_n;
    logic ub_n;
    logic lb_n;
    logic dq_oe;
  } strobe_t;

  localparam strobe_t STROBE_IDLE = '{ce_n: 1'b1, we_n: 1'b1, oe_n: 1'b1,
                                      ub_n: 1'b1, lb_n: 1'b1, dq_oe: 1'b0};

  // Pin levels for a given state of the access; only STROBE pulls weN low on writes.
  function automatic strobe_t strobes_for(arb_state_e st, logic we, logic [1:0] be);
    strobe_t s;
    s = STROBE_IDLE;
    if (st != IDLE) begin
      s.ce_n = 1'b0;
      if (we) begin
        s.dq_oe = 1'b1;
        s.ub_n  = ~be[1];
        s.lb_n  = ~be[0];
        s.we_n  = (st != STROBE);
      end else begin
        s.oe_n = 1'b0;
        s.ub_n = 1'b0;
        s.lb_n = 1'b0;
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/sram_rr_pick.sv
// Combinational round-robin selector: the port after the last grant has priority.
module sram_rr_pick
  import sram_arb_pkg::*;
(
  input  logic [NUM_PORTS-1:0]  req_i,
  input  logic [PORT_IDX_W-1:0] last_grant_i,
  output logic [PORT_IDX_W-1:0] grant_o,
  output logic                  valid_o
);

  logic [PORT_IDX_W-1:0] idx;

  // Walk from the farthest to the nearest candidate so the nearest requester wins.
  always_comb begin
    grant_o = '0;
    valid_o = 1'b0;
    idx     = '0;
    for (int off = NUM_PORTS; off >= 1; off--) begin
      idx = PORT_IDX_W'((int'(last_grant_i) + off) % NUM_PORTS);
      if (req_i[idx]) begin
        grant_o = idx;
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port sequencer for a 256K x 16 asynchronous SRAM; every pin is driven from a register.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ACCESS_CYCLES = 1
) (
  input  logic                   arb_clk_i,
  input  logic                   arb_rstn_i,
  input  logic [NUM_PORTS-1:0]   arb_req_i,
  input  logic [NUM_PORTS-1:0]   arb_we_i,
  input  logic [SRAM_ADDR_W-1:0] arb_addr0_i,
  input  logic [SRAM_ADDR_W-1:0] arb_addr1_i,
  input  logic [SRAM_DATA_W-1:0] arb_wdata0_i,
  input  logic [SRAM_DATA_W-1:0] arb_wdata1_i,
  input  logic [1:0]             arb_be0_i,
  input  logic [1:0]             arb_be1_i,
  output logic [NUM_PORTS-1:0]   arb_ack_o,
  output logic [SRAM_DATA_W-1:0] arb_rdata_o,
  output logic                   arb_busy_o,
  output logic [SRAM_ADDR_W-1:0] sram_addr_o,
  output logic [SRAM_DATA_W-1:0] sram_dq_o,
  output logic                   sram_dqOe_o,
  input  logic [SRAM_DATA_W-1:0] sram_dq_i,
  output logic                   sram_weN_o,
  output logic                   sram_oeN_o,
  output logic                   sram_ubN_o,
  output logic                   sram_lbN_o,
  output logic                   sram_ceN_o
);

  arb_state_e             state_q, state_d;
  xfer_t                  xfer_q, xfer_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [PORT_IDX_W-1:0]  last_grant_q, last_grant_d;
  strobe_t                strb_q;
  logic [NUM_PORTS-1:0]   ack_q, ack_d;
  logic                   busy_q;
  logic [SRAM_DATA_W-1:0] rdata_q;
  logic                   rd_capture;

  logic [PORT_IDX_W-1:0]  pick_idx;
  logic                   pick_valid;

  logic [SRAM_ADDR_W-1:0] port_addr  [NUM_PORTS];
  logic [SRAM_DATA_W-1:0] port_wdata [NUM_PORTS];
  logic [1:0]             port_be    [NUM_PORTS];

  assign port_addr[0]  = arb_addr0_i;
  assign port_addr[1]  = arb_addr1_i;
  assign port_wdata[0] = arb_wdata0_i;
  assign port_wdata[1] = arb_wdata1_i;
  assign port_be[0]    = arb_be0_i;
  assign port_be[1]    = arb_be1_i;

  sram_rr_pick u_pick (
    .req_i        (arb_req_i),
    .last_grant_i (last_grant_q),
    .grant_o      (pick_idx),
    .valid_o      (pick_valid)
  );

  always_comb begin
    state_d      = state_q;
    xfer_d       = xfer_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          xfer_d.we    = arb_we_i[pick_idx];
          xfer_d.addr  = port_addr[pick_idx];
          xfer_d.wdata = port_wdata[pick_idx];
          xfer_d.be    = port_be[pick_idx];
          xfer_d.port  = pick_idx;
          last_grant_d = pick_idx;
          state_d      = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = CNT_W'(ACCESS_CYCLES - 1);
        state_d = STROBE;
      end
      STROBE: begin
        if (cnt_q == '0) begin
          state_d = FINISH;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read data is sampled at the end of the final strobe cycle, while oeN is still low.
  assign rd_capture = (state_q == STROBE) && (cnt_q == '0) && !xfer_q.we;

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_ack
    assign ack_d[gi] = (state_d == FINISH) && (xfer_d.port == PORT_IDX_W'(gi));
  end

  always_ff @(posedge arb_clk_i or negedge arb_rstn_i) begin
    if (!arb_rstn_i) begin
      state_q      <= IDLE;
      xfer_q       <= '0;
      cnt_q        <= '0;
      last_grant_q <= PORT_IDX_W'(NUM_PORTS - 1);
      strb_q       <= STROBE_IDLE;
      ack_q        <= '0;
      busy_q       <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      xfer_q       <= xfer_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      strb_q       <= strobes_for(state_d, xfer_d.we, xfer_d.be);
      ack_q        <= ack_d;
      busy_q       <= (state_d != IDLE);
      if (rd_capture) begin
        rdata_q <= sram_dq_i;
      end
    end
  end

  assign arb_ack_o   = ack_q;
  assign arb_rdata_o = rdata_q;
  assign arb_busy_o  = busy_q;
  assign sram_addr_o = xfer_q.addr;
  assign sram_dq_o   = xfer_q.wdata;
  assign sram_dqOe_o = strb_q.dq_oe;
  assign sram_weN_o  = strb_q.we_n;
  assign sram_oeN_o  = strb_q.oe_n;
  assign sram_ubN_o  = strb_q.ub_n;
  assign sram_lbN_o  = strb_q.lb_n;
  assign sram_ceN_o  = strb_q.ce_n;

endmodule
